// File: rtl/sy_fifo.sv
// Single-clock FIFO with registered empty/full/error flags and registered read data.
// Pointers carry one extra wrap bit so full and empty stay distinguishable across rollovers.
module sy_fifo #(
    parameter int DEPTH         = 16,
    parameter int WIDTH         = 4,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             empty_o,
    output logic             full_o,
    output logic             error_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam logic [ADDRESS_WIDTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0]         mem [DEPTH];
    logic [ADDRESS_WIDTH:0]   wr_ptr, rd_ptr;
    logic [ADDRESS_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt;
    logic                     wr_acc, rd_acc;
    logic                     empty_nxt, full_nxt, error_nxt;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc     = rd_en_i && !empty_o;
        wr_acc     = wr_en_i && (!full_o || rd_acc);
        error_nxt  = (wr_en_i && !wr_acc) || (rd_en_i && empty_o);
        wr_ptr_nxt = wr_acc ? wr_ptr + PTR_ONE : wr_ptr;
        rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[ADDRESS_WIDTH-1:0] == rd_ptr_nxt[ADDRESS_WIDTH-1:0]) &&
                     (wr_ptr_nxt[ADDRESS_WIDTH] != rd_ptr_nxt[ADDRESS_WIDTH]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            empty_o <= 1'b1;
            full_o  <= 1'b0;
            error_o <= 1'b0;
            rdata_o <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            empty_o <= empty_nxt;
            full_o  <= full_nxt;
            error_o <= error_nxt;
            if (rd_acc) begin
                rdata_o <= mem[rd_ptr[ADDRESS_WIDTH-1:0]];
            end
        end
    end

    // Storage is deliberately not cleared by reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (rst_i && wr_acc) begin
            mem[wr_ptr[ADDRESS_WIDTH-1:0]] <= wdata_i;
        end
    end

endmodule

// File: tb/tb_sy_fifo.sv
// Scoreboard bench for sy_fifo: a reference occupancy model and data queue predict every output.
module tb_sy_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             wr_en_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic             empty_o;
    logic             full_o;
    logic             error_o;
    logic [WIDTH-1:0] rdata_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] exp_rdata;
    logic             exp_error;

    sy_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en_i (wr_en_i),
        .rd_en_i (rd_en_i),
        .wdata_i (wdata_i),
        .empty_o (empty_o),
        .full_o  (full_o),
        .error_o (error_o),
        .rdata_o (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".empty"}, {31'd0, empty_o}, {31'd0, sb_q.size() == 0});
        check({tag, ".full"},  {31'd0, full_o},  {31'd0, sb_q.size() == DEPTH});
        check({tag, ".error"}, {31'd0, error_o}, {31'd0, exp_error});
        check({tag, ".rdata"}, {28'd0, rdata_o}, {28'd0, exp_rdata});
    endtask

    // One clock with the given requests; the model decides acceptance from its own occupancy.
    task automatic cycle(input string tag, input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        logic rd_ok, wr_ok;
        rd_ok = rd && (sb_q.size() > 0);
        wr_ok = wr && ((sb_q.size() < DEPTH) || rd_ok);
        exp_error = (wr && !wr_ok) || (rd && sb_q.size() == 0);
        if (rd_ok) exp_rdata = sb_q.pop_front();
        if (wr_ok) sb_q.push_back(d);
        rst_i   = 1'b1;
        wr_en_i = wr;
        rd_en_i = rd;
        wdata_i = d;
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        check_flags(tag);
    endtask

    task automatic do_reset(input int ncyc);
        rst_i   = 1'b0;
        wr_en_i = 1'b1;
        rd_en_i = 1'b0;
        wdata_i = 4'hF;
        repeat (ncyc) @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
        sb_q.delete();
        exp_rdata = '0;
        exp_error = 1'b0;
        check_flags("reset");
    endtask

    initial begin
        rst_i   = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        wdata_i = '0;
        exp_rdata = '0;
        exp_error = 1'b0;

        // Reset with a concurrent write, then an underflow read
        do_reset(2);
        cycle("underflow_after_reset", 1'b0, 1'b1, 4'h0);
        cycle("idle_error_clears", 1'b0, 1'b0, 4'h0);

        // Fill and drain in order
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, WIDTH'(i));
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 4'h0);

        // Overflow: the extra write is rejected and never stored
        for (int i = 0; i < DEPTH; i++) cycle("ovf_fill", 1'b1, 1'b0, WIDTH'(i));
        cycle("overflow", 1'b1, 1'b0, 4'hA);
        cycle("overflow_clear", 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < DEPTH; i++) cycle("ovf_drain", 1'b0, 1'b1, 4'h0);

        // Simultaneous write and read on empty: read underflows, write lands
        cycle("empty_wr_rd", 1'b1, 1'b1, 4'h5);
        cycle("read_5", 1'b0, 1'b1, 4'h0);

        // Back-to-back underflows keep error high
        cycle("uflow_a", 1'b0, 1'b1, 4'h0);
        cycle("uflow_b", 1'b0, 1'b1, 4'h0);

        // Full with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) cycle("full_fill", 1'b1, 1'b0, WIDTH'(i));
        cycle("full_wr_rd", 1'b1, 1'b1, 4'hC);
        for (int i = 0; i < DEPTH; i++) cycle("full_drain", 1'b0, 1'b1, 4'h0);

        // Streaming across pointer rollover with occupancy one
        cycle("prime", 1'b1, 1'b0, 4'h3);
        for (int i = 0; i < 40; i++) cycle("stream", 1'b1, 1'b1, WIDTH'(i + 7));
        cycle("stream_last", 1'b0, 1'b1, 4'h0);

        // Reset mid-operation discards contents
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b0, WIDTH'(i + 9));
        do_reset(1);
        cycle("post_rst_wr", 1'b1, 1'b0, 4'h7);
        cycle("post_rst_rd", 1'b0, 1'b1, 4'h0);
        cycle("post_rst_empty", 1'b0, 1'b1, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
